// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the mod_counter timebase/event counter.
package mod_counter_pkg;

  // Overflow behaviour at the range limits.
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Counting direction as seen on the 'up' input.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Ceiling log2, used to size the prescaler; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mod_counter_prescale.sv
// Enabled-cycle divider for mod_counter: raises step on every PRESCALE-th
// enabled cycle. restart (clear/load in the parent) returns it to phase 0.
module mod_counter_prescale
  import mod_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic step
);

  localparam int PW = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  assign step = en && !restart && (phase == LAST);

  // Phase counter advances only on enabled cycles, wrapping after LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (restart) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == LAST) ? '0 : phase + PW'(1);
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with clear, clamped load, wrap/saturate mode and
// registered terminal-count / event outputs.
// Optional feature: define MOD_COUNTER_PRESCALE_EN to make the counter step
// only on every PRESCALE-th enabled cycle.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX      = 2**WIDTH - 1,
  parameter int SATURATE = MODE_WRAP,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             evt
);

  // One spare bit so the limit compares and +/-1 never alias at 2**WIDTH.
  localparam logic [WIDTH:0] MAX_X = (WIDTH + 1)'(MAX);
  localparam logic [WIDTH:0] ONE_X = (WIDTH + 1)'(1);

  if (WIDTH < 1 || MAX < 0 || MAX > 2**WIDTH - 1 || PRESCALE < 1) begin : g_param_check
    $error("mod_counter: illegal WIDTH/MAX/PRESCALE combination");
  end

  logic           step;
  logic [WIDTH:0] cur_x;
  logic [WIDTH:0] load_x;
  logic [WIDTH:0] nxt_x;
  logic           nxt_evt;
  logic           nxt_tc;

`ifdef MOD_COUNTER_PRESCALE_EN
  mod_counter_prescale #(
    .PRESCALE(PRESCALE)
  ) u_prescale (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(clr | load),
    .en     (en),
    .step   (step)
  );
`else
  assign step = en;
`endif

  // Next count/event with clr > load > step priority; tc follows next count.
  always_comb begin
    cur_x   = {1'b0, count};
    load_x  = {1'b0, load_val};
    nxt_x   = cur_x;
    nxt_evt = 1'b0;
    if (clr) begin
      nxt_x = '0;
    end else if (load) begin
      nxt_x = (load_x > MAX_X) ? MAX_X : load_x;
    end else if (step) begin
      if (up == DIR_UP) begin
        if (cur_x >= MAX_X) begin
          nxt_evt = 1'b1;
          nxt_x   = (SATURATE == MODE_SAT) ? MAX_X : '0;
        end else begin
          nxt_x = cur_x + ONE_X;
        end
      end else begin
        if (cur_x == '0) begin
          nxt_evt = 1'b1;
          nxt_x   = (SATURATE == MODE_SAT) ? '0 : MAX_X;
        end else begin
          nxt_x = cur_x - ONE_X;
        end
      end
    end
    nxt_tc = (up == DIR_UP) ? (nxt_x == MAX_X) : (nxt_x == '0);
  end

  // Output registers; reset aborts any pending event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tc    <= 1'b0;
      evt   <= 1'b0;
    end else begin
      count <= nxt_x[WIDTH-1:0];
      tc    <= nxt_tc;
      evt   <= nxt_evt;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: three instances (MAX=15 wrap, MAX=9 wrap, MAX=9
// saturate) share one stimulus stream and are checked against a model.
module tb_mod_counter;

`ifdef MOD_COUNTER_PRESCALE_EN
  localparam int PS = 3;
`else
  localparam int PS = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       up;
  logic [3:0] cnt_o [3];
  logic       tc_o  [3];
  logic       evt_o [3];

  int total = 0;
  int bad   = 0;

  int mx  [3] = '{15, 9, 9};
  int sat [3] = '{0, 0, 1};
  int m_cnt [3];
  int m_tc  [3];
  int m_evt [3];
  int m_pre;

  mod_counter #(.WIDTH(4), .MAX(15), .SATURATE(0), .PRESCALE(3)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(cnt_o[0]), .tc(tc_o[0]), .evt(evt_o[0]));
  mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(0), .PRESCALE(3)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(cnt_o[1]), .tc(tc_o[1]), .evt(evt_o[1]));
  mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1), .PRESCALE(3)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(cnt_o[2]), .tc(tc_o[2]), .evt(evt_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_tc[i]  = 0;
      m_evt[i] = 0;
    end
    m_pre = 0;
  endtask

  // Reference: modular arithmetic on plain integers, one edge at a time.
  task automatic model_step();
    bit stp;
    stp = en && (m_pre == PS - 1);
    for (int i = 0; i < 3; i++) begin
      int c;
      int e;
      c = m_cnt[i];
      e = 0;
      if (clr) c = 0;
      else if (load) c = (int'(load_val) < mx[i]) ? int'(load_val) : mx[i];
      else if (stp) begin
        if (up) begin
          e = (c == mx[i]);
          c = sat[i] ? ((c + 1 > mx[i]) ? mx[i] : c + 1) : (c + 1) % (mx[i] + 1);
        end else begin
          e = (c == 0);
          c = sat[i] ? ((c == 0) ? 0 : c - 1) : (c + mx[i]) % (mx[i] + 1);
        end
      end
      m_cnt[i] = c;
      m_evt[i] = e;
      m_tc[i]  = up ? (c == mx[i]) : (c == 0);
    end
    if (clr || load) m_pre = 0;
    else if (en)     m_pre = (m_pre + 1) % PS;
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s count[%0d]", tag, i), int'(cnt_o[i]), m_cnt[i]);
      chk($sformatf("%s tc[%0d]", tag, i), int'(tc_o[i]), m_tc[i]);
      chk($sformatf("%s evt[%0d]", tag, i), int'(evt_o[i]), m_evt[i]);
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    int clr; int load; int lv; int en; int up;
    int c0; int c1; int c2;
    int t0; int t1; int t2;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int s;
    int k;
    tbl[0] = '{1, 1,  5, 1, 1,  0, 0, 0,  0, 0, 0};
    tbl[1] = '{0, 1,  3, 1, 1,  3, 3, 3,  0, 0, 0};
    tbl[2] = '{0, 1, 12, 1, 1, 12, 9, 9,  0, 1, 1};
    tbl[3] = '{0, 1, 15, 1, 1, 15, 9, 9,  1, 1, 1};
    tbl[4] = '{0, 1,  0, 1, 0,  0, 0, 0,  1, 1, 1};
    tbl[5] = '{1, 0,  7, 1, 0,  0, 0, 0,  1, 1, 1};
    tbl[6] = '{0, 1,  9, 0, 0,  9, 9, 9,  0, 0, 0};
    tbl[7] = '{0, 1, 10, 0, 1, 10, 9, 9,  0, 1, 1};

    rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b1;
    model_reset();
    #12;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running up count from reset, checked against closed forms.
    en = 1'b1; up = 1'b1;
    for (k = 1; k <= 32 * PS; k++) begin
      tick("run_up");
      s = k / PS;
      chk("run_up a count", int'(cnt_o[0]), s % 16);
      chk("run_up a evt", int'(evt_o[0]), int'((k % PS == 0) && (s % 16 == 0)));
      chk("run_up a tc", int'(tc_o[0]), int'(s % 16 == 15));
      chk("run_up b count", int'(cnt_o[1]), s % 10);
      chk("run_up c count", int'(cnt_o[2]), (s > 9) ? 9 : s);
      chk("run_up c evt", int'(evt_o[2]), int'((k % PS == 0) && (s >= 10)));
    end

    // Clear/load priority and clamping table.
    for (int r = 0; r < 8; r++) begin
      clr = tbl[r].clr[0]; load = tbl[r].load[0]; load_val = 4'(tbl[r].lv);
      en = tbl[r].en[0]; up = tbl[r].up[0];
      tick("table");
      chk($sformatf("tbl%0d count0", r), int'(cnt_o[0]), tbl[r].c0);
      chk($sformatf("tbl%0d count1", r), int'(cnt_o[1]), tbl[r].c1);
      chk($sformatf("tbl%0d count2", r), int'(cnt_o[2]), tbl[r].c2);
      chk($sformatf("tbl%0d tc0", r), int'(tc_o[0]), tbl[r].t0);
      chk($sformatf("tbl%0d tc1", r), int'(tc_o[1]), tbl[r].t1);
      chk($sformatf("tbl%0d tc2", r), int'(tc_o[2]), tbl[r].t2);
      chk($sformatf("tbl%0d evt0", r), int'(evt_o[0]), 0);
    end

    // Enable pause: count and prescaler phase must both freeze.
    clr = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1;
    tick("pause clr");
    clr = 1'b0; en = 1'b1;
    repeat (3 * PS) tick("pause run");
    chk("pause count before", int'(cnt_o[0]), 3);
    en = 1'b0;
    repeat (2) tick("pause hold");
    chk("pause count held", int'(cnt_o[0]), 3);
    en = 1'b1;
    repeat (PS - 1) tick("pause resume");
    chk("pause no early step", int'(cnt_o[0]), 3);
    tick("pause resume");
    chk("pause step after", int'(cnt_o[0]), 4);

    // Direction flip at a wrap boundary on the MAX=9 instance.
    load = 1'b1; load_val = 4'd2; en = 1'b1; up = 1'b0;
    tick("dn load");
    load = 1'b0;
    repeat (3 * PS) tick("dn run");
    chk("dn wrap count b", int'(cnt_o[1]), 9);
    chk("dn sat count c", int'(cnt_o[2]), 0);

    // Asynchronous reset between edges at count 6.
    load = 1'b1; load_val = 4'd6; en = 1'b0; up = 1'b1;
    tick("ar load");
    load = 1'b0; en = 1'b1;
    tick("ar run");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async count", int'(cnt_o[0]), 0);
    chk("async tc", int'(tc_o[1]), 0);
    chk("async evt", int'(evt_o[2]), 0);
    check_model("async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (PS) tick("after reset");
    chk("resume count", int'(cnt_o[0]), 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      clr      = ($urandom_range(0, 39) == 0);
      load     = ($urandom_range(0, 29) == 0);
      load_val = 4'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) up = ~up;
      tick("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised up/down modulo counter; successor to the free-running WIDTH-bit counter.
- Adds the following over a plain free-running counter:
  - programmable modulus (MAX);
  - count enable and direction;
  - synchronous clear and parallel load;
  - wrap or saturate mode;
  - registered terminal-count and wrap/saturate event pulses.
- Used as the common timebase/event counter for timers, baud dividers and loop controllers in the design.

Parameters:
- WIDTH, 4, counter width in bits (>= 1).
- MAX, 2**WIDTH-1, terminal value. Count range is 0..MAX. Must satisfy MAX <= 2**WIDTH-1.
- SATURATE, 0, overflow mode. 0 = wrap, 1 = saturate at the range limits.
- PRESCALE, 1, enabled-cycle divider. Used only when MOD_COUNTER_PRESCALE_EN is defined. Must be >= 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- en  input  1  count enable.
- up  input  1  direction. 1 = increment, 0 = decrement.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal count, registered. 1 when count==MAX (counting up) or count==0 (counting down).
- evt  output  1  registered one-cycle pulse on each wrap or saturation hit.

Behaviour:
- Reset: rst_n low asynchronously forces count=0, tc=0, evt=0 and the prescaler to 0. Release is synchronous to the next clk rising edge.
- Priority per rising edge: clr > load > en. If none is active, count holds and evt=0.
- Latency: count, tc and evt reflect the inputs sampled on the same rising edge. There are no combinational paths from inputs to outputs.
- clr: count <= 0; evt <= 0.
- load: count <= min(load_val, MAX); evt <= 0.
  - Loading a value > MAX clamps to MAX; no error flag.
- en with up=1:
  - count < MAX: count <= count+1.
  - count == MAX, SATURATE=0: count <= 0, evt <= 1.
  - count == MAX, SATURATE=1: count holds at MAX, evt <= 1 on every enabled cycle at the limit.
- en with up=0:
  - count > 0: count <= count-1.
  - count == 0, SATURATE=0: count <= MAX, evt <= 1.
  - count == 0, SATURATE=1: count holds at 0, evt <= 1.
- Arithmetic: performed at WIDTH+1 bits. Comparisons are against MAX only, never against 2**WIDTH. MAX < 2**WIDTH-1 gives a true modulo-(MAX+1) sequence.
- tc: registered, computed from the next count and the direction sampled on that edge.
  - up=1: tc = (next==MAX).
  - up=0: tc = (next==0).
  - When en is low, tc is still recomputed from the held count and the current up.
- Direction change while enabled takes effect on the same edge. There is no turnaround bubble.
- Reset mid-count aborts immediately; no pending event survives.
- WIDTH=1, MAX=1 is legal and behaves as a toggle.

Optional Feature:
- Macro: MOD_COUNTER_PRESCALE_EN.
- Defined:
  - an internal prescaler counts enabled cycles modulo PRESCALE;
  - the main counter steps only when the prescaler is at PRESCALE-1 and en=1;
  - clr and load also reset the prescaler to 0;
  - evt fires only on stepping edges.
- Undefined:
  - the main counter steps on every enabled cycle;
  - the PRESCALE parameter is ignored;
  - no prescaler flops are present.

Decomposition:
- Shared package/include mod_counter_pkg holds:
  - mode constants MODE_WRAP=0 and MODE_SAT=1;
  - the direction constants DIR_UP=1 and DIR_DOWN=0;
  - a clog2 function for sizing the prescaler.
- One sub-module, mod_counter_prescale:
  - ports: clk, rst_n, restart, en, step;
  - instantiated only under MOD_COUNTER_PRESCALE_EN.
- The core next-state logic stays in mod_counter.

Test Plan:
1. WIDTH=4, MAX=15, SATURATE=0, en=1, up=1 for 32 cycles after reset:
   - count follows 0,1,..,15,0,..,15;
   - evt pulses twice, on the cycles count becomes 0;
   - tc=1 exactly when count=15.
2. WIDTH=4, MAX=9, up=1 from 0 for 12 cycles:
   - count reaches 9 then 0;
   - evt=1 once;
   - then switch up=0 at count=2: count goes 1,0,9 and evt pulses at 9.
3. SATURATE=1, MAX=9: load 7 then count up 5 cycles:
   - count is 8,9,9,9,9;
   - evt=1 on each of the last three edges;
   - then load_val=12 results in count=9.
4. clr, load and en all high with load_val=5 at count=6: next count=0.
   - Then load=1 and en=1, load_val=3: count=3 and no step.
5. Assert rst_n low mid-count at count=6, asynchronously between edges:
   - count, tc and evt go 0 immediately;
   - counting resumes at 1 on the first enabled edge after release.
6. With MOD_COUNTER_PRESCALE_EN, PRESCALE=3, en=1, up=1:
   - count increments every 3rd cycle;
   - en low for 2 cycles pauses both the prescaler and count;
   - clr resets both counters.
